instr_prefetch_queue: RTL

Fetch-side front end that sits directly upstream of the pipeline's IF/ID register. It owns the fetch PC and issues in-order requests to a variable-latency instruction memory over a valid/ready port. Returned instructions are buffered with their PCs in a small FIFO and presented to IF/ID. It honours the hazard-stall signal and the branch-unit redirect/flush, and discards any responses that are stale after a redirect.

---
 rtl/instr_prefetch_queue_pkg.sv | 12 +
 rtl/instr_prefetch_queue_sync_fifo.sv | 40 ++++
 rtl/instr_prefetch_queue.sv | 76 +++++++
 3 files changed

// File: rtl/instr_prefetch_queue_pkg.sv
// instr_prefetch_queue_pkg: fetch-entry type and default sizing shared by the fetch front end
package instr_prefetch_queue_pkg;
    localparam int FETCH_PC_W = 9;
    localparam int FETCH_INS_W = 32;
    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_MAX_OUTST = 2;
    localparam logic [FETCH_INS_W-1:0] NOP_INSTR = 32'h0;
    typedef struct packed {
        logic [FETCH_PC_W-1:0] pc;
        logic [FETCH_INS_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/instr_prefetch_queue_sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with clear, entry count and combinational head
module sync_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic push,
    input  logic [W-1:0] push_data,
    input  logic pop,
    output logic [W-1:0] head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    always_ff @(posedge clk)
        if (push && !clear) mem[wr_ptr] <= push_data;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    assign head = mem[rd_ptr];
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && !clear && count == (AW+1)'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        !(pop && !clear && count == '0));
endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: owns the fetch PC, issues in-order imem requests and buffers
// returned instructions with their PCs for the IF/ID register
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int PC_W = FETCH_PC_W,
    parameter int INS_W = FETCH_INS_W,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int MAX_OUTST = DEFAULT_MAX_OUTST,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic reset,
    output logic imem_req_valid,
    input  logic imem_req_ready,
    output logic [PC_W-1:0] imem_req_addr,
    input  logic imem_rsp_valid,
    input  logic [INS_W-1:0] imem_rsp_data,
    input  logic stall,
    input  logic redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic if_valid,
    output logic [PC_W-1:0] if_pc,
    output logic [INS_W-1:0] if_instr,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [PC_W-1:0] fetch_pc, tag_pc;
    logic [CW-1:0] outstanding, drop_cnt;
    logic req_fire, push, pop, unused;
    fetch_entry_t head, rsp_entry;
    // credits count queued plus in-flight entries so a response always finds room
    assign imem_req_valid = reset && !redirect && outstanding < CW'(MAX_OUTST) &&
                            ({1'b0, occupancy} + {1'b0, outstanding} < (CW+1)'(DEPTH));
    assign imem_req_addr = fetch_pc;
    assign req_fire = imem_req_valid && imem_req_ready;
    assign push = imem_rsp_valid && !redirect && drop_cnt == '0;
    assign pop = if_valid && !stall && !redirect;
    assign rsp_entry = '{pc: tag_pc, instr: imem_rsp_data};
    assign if_valid = occupancy != '0;
    assign if_pc = if_valid ? head.pc : '0;
    assign if_instr = if_valid ? head.instr : NOP_INSTR;
    assign unused = ^redirect_pc[1:0];
    sync_fifo #(.W(PC_W), .DEPTH(DEPTH)) u_tag_q (
        .clk(clk),
        .reset(reset),
        .clear(1'b0),
        .push(req_fire),
        .push_data(fetch_pc),
        .pop(imem_rsp_valid),
        .head(tag_pc),
        .count(outstanding)
    );
    sync_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_data_q (
        .clk(clk),
        .reset(reset),
        .clear(redirect),
        .push(push),
        .push_data(rsp_entry),
        .pop(pop),
        .head(head),
        .count(occupancy)
    );
    // every request still in flight at a redirect is stale; earlier drops are a subset of it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            fetch_pc <= redirect ? {redirect_pc[PC_W-1:2], 2'b00} : req_fire ? fetch_pc + PC_W'(4) : fetch_pc;
            drop_cnt <= redirect ? outstanding - CW'(imem_rsp_valid) : drop_cnt - CW'(imem_rsp_valid && drop_cnt != '0);
        end
    end
    a_rsp_expected: assert property (@(posedge clk) disable iff (!reset)
        imem_rsp_valid |-> outstanding != '0);
endmodule
